sw_seq_gen: RTL and testbench

- Generates the DEPFET switcher control sequence (SW_GATE, SW_CLEAR, SW_FRAME, SW_CLK) as 16-bit parallel words, 4 samples per CLK_80 cycle (320 MHz sample rate).
- Output feeds a 4:1 output serializer, the transmit counterpart of the switcher deserializer in the DCD emulator path.
- Each frame consists of CFG_NROWS rows of CFG_ROW_LEN samples, and row boundaries may fall mid-word.
- Used to drive the emulator's switcher inputs for closed-loop testing.

---
 rtl/sw_seq_gen.sv | 191 +++++++++++++++++++
 tb/tb_sw_seq_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sw_seq_gen.sv
// DEPFET switcher sequence generator: emits GATE/CLEAR/FRAME/CLK as 4-sample words
// per CLK_80 cycle for a 4:1 output serializer.
module sw_seq_gen #(
  parameter int ROW_W = 8,
  parameter int SMP_W = 10
) (
  input  logic             CLK_80,
  input  logic             RST_N,
  input  logic             START,
  input  logic             STOP,
  input  logic             CFG_CONT,
  input  logic [ROW_W-1:0] CFG_NROWS,
  input  logic [SMP_W-1:0] CFG_ROW_LEN,
  input  logic [SMP_W-1:0] CFG_CLK_HI,
  input  logic [SMP_W-1:0] CFG_GATE_ON,
  input  logic [SMP_W-1:0] CFG_GATE_OFF,
  input  logic [SMP_W-1:0] CFG_CLEAR_ON,
  input  logic [SMP_W-1:0] CFG_CLEAR_OFF,
  output logic [15:0]      SW_SEQ,
  output logic             BUSY,
  output logic             FRAME_DONE,
  output logic [ROW_W-1:0] ROW
);

  localparam int PW = SMP_W + 1;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t state_q, state_d;

  // Shadow copy of the configuration, frozen for the whole run.
  logic             cont_q;
  logic [ROW_W-1:0] last_row_q;
  logic [SMP_W-1:0] row_len_q, clk_hi_q;
  logic [SMP_W-1:0] gate_on_q, gate_off_q, clear_on_q, clear_off_q;

  logic [SMP_W-1:0] pos_q, pos_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             stop_req_q, stop_req_d;
  logic             load;

  logic [15:0]      word_d;
  logic             busy_d, done_d;
  logic [ROW_W-1:0] row_out_d;

  logic             start_ok;
  assign start_ok = START && (CFG_NROWS != '0) && (CFG_ROW_LEN >= SMP_W'(4));

  always_comb begin
    logic             stop_eff, last_row, keep_going, wrap, active, first_row;
    logic [PW-1:0]    q, sum;
    logic [SMP_W-1:0] p;
    logic             s_clk, s_gate, s_clear;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d    = state_q;
    pos_d      = pos_q;
    row_d      = row_q;
    stop_req_d = stop_req_q;
    load       = 1'b0;
    word_d     = '0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    row_out_d  = '0;
    stop_eff   = 1'b0;
    last_row   = 1'b0;
    keep_going = 1'b0;
    wrap       = 1'b0;
    active     = 1'b0;
    first_row  = 1'b0;
    q          = '0;
    sum        = '0;
    p          = '0;
    s_clk      = 1'b0;
    s_gate     = 1'b0;
    s_clear    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          load       = 1'b1;
          pos_d      = '0;
          row_d      = '0;
          stop_req_d = 1'b0;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        // A STOP arriving in the frame-end cycle still ends this frame.
        stop_eff   = stop_req_q | STOP;
        stop_req_d = stop_eff;
        busy_d     = 1'b1;
        row_out_d  = row_q;
        last_row   = (row_q == last_row_q);
        keep_going = cont_q && !stop_eff;

        for (int k = 0; k < 4; k++) begin
          q    = {1'b0, pos_q} + PW'(k);
          wrap = (q >= {1'b0, row_len_q});
          if (wrap) begin
            p         = SMP_W'(q - {1'b0, row_len_q});
            // Past the last row: either the next frame's row 0, or dead time.
            active    = last_row ? keep_going : 1'b1;
            first_row = last_row;
          end else begin
            p         = SMP_W'(q);
            active    = 1'b1;
            first_row = (row_q == '0);
          end
          s_clk   = (p < clk_hi_q);
          s_gate  = (p >= gate_on_q) && (p < gate_off_q);
          s_clear = (p >= clear_on_q) && (p < clear_off_q);
          if (active) begin
            word_d[4*k +: 4] = {s_gate, s_clear, first_row & s_clk, s_clk};
          end
        end

        sum = {1'b0, pos_q} + PW'(4);
        if (sum >= {1'b0, row_len_q}) begin
          pos_d = SMP_W'(sum - {1'b0, row_len_q});
          if (last_row) begin
            done_d = 1'b1;
            row_d  = '0;
            if (!keep_going) begin
              state_d = S_IDLE;
            end
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else begin
          pos_d = SMP_W'(sum);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge CLK_80 or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      pos_q      <= '0;
      row_q      <= '0;
      stop_req_q <= 1'b0;
      SW_SEQ     <= '0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
      ROW        <= '0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      row_q      <= row_d;
      stop_req_q <= stop_req_d;
      SW_SEQ     <= word_d;
      BUSY       <= busy_d;
      FRAME_DONE <= done_d;
      ROW        <= row_out_d;
    end
  end

  // NOTE: the shadow config is reset as well, so RUN-state compares never see X
  // even if a bench or upstream block drives CFG_* late.
  always_ff @(posedge CLK_80 or negedge RST_N) begin
    if (!RST_N) begin
      cont_q      <= 1'b0;
      last_row_q  <= '0;
      row_len_q   <= '0;
      clk_hi_q    <= '0;
      gate_on_q   <= '0;
      gate_off_q  <= '0;
      clear_on_q  <= '0;
      clear_off_q <= '0;
    end else if (load) begin
      cont_q      <= CFG_CONT;
      last_row_q  <= CFG_NROWS - ROW_W'(1);
      row_len_q   <= CFG_ROW_LEN;
      clk_hi_q    <= CFG_CLK_HI;
      gate_on_q   <= CFG_GATE_ON;
      gate_off_q  <= CFG_GATE_OFF;
      clear_on_q  <= CFG_CLEAR_ON;
      clear_off_q <= CFG_CLEAR_OFF;
    end
  end

endmodule

// File: tb/tb_sw_seq_gen.sv
// Directed bench for sw_seq_gen: table of per-scenario configs and expected words,
// plus hand-written sequences for restart, config change and mid-frame reset.
module tb_sw_seq_gen;

  logic       CLK_80 = 1'b0;
  logic       RST_N;
  logic       START, STOP, CFG_CONT;
  logic [7:0] CFG_NROWS;
  logic [9:0] CFG_ROW_LEN, CFG_CLK_HI, CFG_GATE_ON, CFG_GATE_OFF, CFG_CLEAR_ON, CFG_CLEAR_OFF;
  logic [15:0] SW_SEQ;
  logic       BUSY, FRAME_DONE;
  logic [7:0] ROW;

  sw_seq_gen #(.ROW_W(8), .SMP_W(10)) dut (
    .CLK_80       (CLK_80),
    .RST_N        (RST_N),
    .START        (START),
    .STOP         (STOP),
    .CFG_CONT     (CFG_CONT),
    .CFG_NROWS    (CFG_NROWS),
    .CFG_ROW_LEN  (CFG_ROW_LEN),
    .CFG_CLK_HI   (CFG_CLK_HI),
    .CFG_GATE_ON  (CFG_GATE_ON),
    .CFG_GATE_OFF (CFG_GATE_OFF),
    .CFG_CLEAR_ON (CFG_CLEAR_ON),
    .CFG_CLEAR_OFF(CFG_CLEAR_OFF),
    .SW_SEQ       (SW_SEQ),
    .BUSY         (BUSY),
    .FRAME_DONE   (FRAME_DONE),
    .ROW          (ROW)
  );

  always #5 CLK_80 = ~CLK_80;

  typedef struct packed {
    logic       cont;
    logic [7:0] nrows;
    logic [9:0] row_len, clk_hi, gate_on, gate_off, clear_on, clear_off;
  } cfg_t;

  typedef struct {
    logic [15:0] seq;
    logic        done;
    logic        busy;
    logic [7:0]  row;
  } exp_t;

  typedef struct {
    string name;
    cfg_t  cfg;
    int    first;
    int    count;
    int    stop_at;
  } scen_t;

  exp_t  exp_tbl[29];
  scen_t scen_tbl[6];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic exp_t e(input logic [15:0] seq, input logic done, input logic busy,
                             input logic [7:0] row);
    exp_t r;
    r.seq = seq; r.done = done; r.busy = busy; r.row = row;
    return r;
  endfunction

  task automatic apply_cfg(input cfg_t c);
    CFG_CONT      = c.cont;
    CFG_NROWS     = c.nrows;
    CFG_ROW_LEN   = c.row_len;
    CFG_CLK_HI    = c.clk_hi;
    CFG_GATE_ON   = c.gate_on;
    CFG_GATE_OFF  = c.gate_off;
    CFG_CLEAR_ON  = c.clear_on;
    CFG_CLEAR_OFF = c.clear_off;
  endtask

  // Leaves us at the negedge just after the edge that sampled START.
  task automatic start_pulse(input string name);
    @(negedge CLK_80) START = 1'b1;
    @(negedge CLK_80) START = 1'b0;
    check($sformatf("%s latency busy", name), {31'd0, BUSY}, 32'd0);
  endtask

  task automatic check_word(input string name, input int i, input exp_t x);
    check($sformatf("%s w%0d seq", name, i), {16'd0, SW_SEQ}, {16'd0, x.seq});
    check($sformatf("%s w%0d done", name, i), {31'd0, FRAME_DONE}, {31'd0, x.done});
    check($sformatf("%s w%0d busy", name, i), {31'd0, BUSY}, {31'd0, x.busy});
    check($sformatf("%s w%0d row", name, i), {24'd0, ROW}, {24'd0, x.row});
  endtask

  task automatic run_scen(input scen_t s);
    apply_cfg(s.cfg);
    start_pulse(s.name);
    for (int i = 0; i < s.count; i++) begin
      @(negedge CLK_80);
      check_word(s.name, i, exp_tbl[s.first + i]);
      STOP = (i == s.stop_at);
    end
    STOP = 1'b0;
  endtask

  cfg_t cfg_a, cfg_b, cfg_d, cfg_e, cfg_bad;

  initial begin
    cfg_a = '{cont:1'b0, nrows:8'd2, row_len:10'd8, clk_hi:10'd4,
              gate_on:10'd1, gate_off:10'd3, clear_on:10'd5, clear_off:10'd7};
    cfg_b = '{cont:1'b0, nrows:8'd2, row_len:10'd6, clk_hi:10'd3,
              gate_on:10'd0, gate_off:10'd0, clear_on:10'd0, clear_off:10'd0};
    cfg_d = '{cont:1'b0, nrows:8'd1, row_len:10'd4, clk_hi:10'd2,
              gate_on:10'd0, gate_off:10'd0, clear_on:10'd0, clear_off:10'd0};
    cfg_e = '{cont:1'b1, nrows:8'd1, row_len:10'd5, clk_hi:10'd2,
              gate_on:10'd0, gate_off:10'd0, clear_on:10'd0, clear_off:10'd0};

    // Scenario A: two rows of 8.
    exp_tbl[0]  = e(16'h3BB3, 1'b0, 1'b1, 8'd0);
    exp_tbl[1]  = e(16'h0440, 1'b0, 1'b1, 8'd0);
    exp_tbl[2]  = e(16'h1991, 1'b0, 1'b1, 8'd1);
    exp_tbl[3]  = e(16'h0440, 1'b1, 1'b1, 8'd1);
    exp_tbl[4]  = e(16'h0000, 1'b0, 1'b0, 8'd0);
    // Scenario B: rows of 6, boundary mid-word.
    exp_tbl[5]  = e(16'h0333, 1'b0, 1'b1, 8'd0);
    exp_tbl[6]  = e(16'h1100, 1'b0, 1'b1, 8'd0);
    exp_tbl[7]  = e(16'h0001, 1'b1, 1'b1, 8'd1);
    exp_tbl[8]  = e(16'h0000, 1'b0, 1'b0, 8'd0);
    // Minimum row length 4, single row.
    exp_tbl[9]  = e(16'h0033, 1'b1, 1'b1, 8'd0);
    exp_tbl[10] = e(16'h0000, 1'b0, 1'b0, 8'd0);
    // A continuous, STOP during word 6.
    for (int f = 0; f < 2; f++) begin
      exp_tbl[11 + 4*f] = e(16'h3BB3, 1'b0, 1'b1, 8'd0);
      exp_tbl[12 + 4*f] = e(16'h0440, 1'b0, 1'b1, 8'd0);
      exp_tbl[13 + 4*f] = e(16'h1991, 1'b0, 1'b1, 8'd1);
      exp_tbl[14 + 4*f] = e(16'h0440, 1'b1, 1'b1, 8'd1);
    end
    exp_tbl[19] = e(16'h0000, 1'b0, 1'b0, 8'd0);
    // Continuous 5-sample frames wrapping mid-word; STOP coincides with a frame end.
    exp_tbl[20] = e(16'h0033, 1'b0, 1'b1, 8'd0);
    exp_tbl[21] = e(16'h0330, 1'b1, 1'b1, 8'd0);
    exp_tbl[22] = e(16'h3300, 1'b1, 1'b1, 8'd0);
    exp_tbl[23] = e(16'h3000, 1'b1, 1'b1, 8'd0);
    exp_tbl[24] = e(16'h0003, 1'b1, 1'b1, 8'd0);
    exp_tbl[25] = e(16'h0000, 1'b0, 1'b0, 8'd0);
    // Same, STOP early: samples after the frame end are blanked.
    exp_tbl[26] = e(16'h0033, 1'b0, 1'b1, 8'd0);
    exp_tbl[27] = e(16'h0000, 1'b1, 1'b1, 8'd0);
    exp_tbl[28] = e(16'h0000, 1'b0, 1'b0, 8'd0);

    scen_tbl[0] = '{name:"A",      cfg:cfg_a, first:0,  count:5, stop_at:-1};
    scen_tbl[1] = '{name:"B",      cfg:cfg_b, first:5,  count:4, stop_at:-1};
    scen_tbl[2] = '{name:"len4",   cfg:cfg_d, first:9,  count:2, stop_at:-1};
    scen_tbl[3] = '{name:"contA",  cfg:cfg_a, first:11, count:9, stop_at:5};
    scen_tbl[3].cfg.cont = 1'b1;
    scen_tbl[4] = '{name:"contE",  cfg:cfg_e, first:20, count:6, stop_at:3};
    scen_tbl[5] = '{name:"stopE",  cfg:cfg_e, first:26, count:3, stop_at:0};

    RST_N = 1'b0;
    START = 1'b0;
    STOP  = 1'b0;
    apply_cfg(cfg_a);
    repeat (2) @(negedge CLK_80);
    check_word("reset", 0, e(16'h0000, 1'b0, 1'b0, 8'd0));
    RST_N = 1'b1;
    @(negedge CLK_80);

    for (int s = 0; s < 6; s++) run_scen(scen_tbl[s]);

    // Rejected starts.
    cfg_bad = cfg_a; cfg_bad.nrows = 8'd0;
    apply_cfg(cfg_bad);
    start_pulse("nrows0");
    repeat (3) begin
      @(negedge CLK_80);
      check("nrows0 busy", {31'd0, BUSY}, 32'd0);
      check("nrows0 seq", {16'd0, SW_SEQ}, 32'd0);
    end
    cfg_bad = cfg_a; cfg_bad.row_len = 10'd3;
    apply_cfg(cfg_bad);
    start_pulse("len3");
    repeat (3) begin
      @(negedge CLK_80);
      check("len3 busy", {31'd0, BUSY}, 32'd0);
      check("len3 seq", {16'd0, SW_SEQ}, 32'd0);
    end

    // Second START plus config change mid-run: A still completes unchanged.
    apply_cfg(cfg_a);
    start_pulse("restart");
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK_80);
      check_word("restart", i, exp_tbl[i]);
      if (i == 0) begin
        apply_cfg(cfg_b);
        START = 1'b1;
      end else begin
        START = 1'b0;
      end
    end
    run_scen(scen_tbl[1]);

    // Reset during word 2 of A.
    apply_cfg(cfg_a);
    start_pulse("rst");
    @(negedge CLK_80);
    check_word("rst", 0, exp_tbl[0]);
    @(negedge CLK_80);
    check_word("rst", 1, exp_tbl[1]);
    #2 RST_N = 1'b0;
    #1;
    check("rst async seq", {16'd0, SW_SEQ}, 32'd0);
    check("rst async busy", {31'd0, BUSY}, 32'd0);
    @(negedge CLK_80) RST_N = 1'b1;
    repeat (3) begin
      @(negedge CLK_80);
      check("rst no done", {31'd0, FRAME_DONE}, 32'd0);
      check("rst idle busy", {31'd0, BUSY}, 32'd0);
    end
    run_scen(scen_tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
